// File: rtl/scan_mux_pkg.sv
// Shared definitions for the pipelined N-channel selector.
// Mode encodings are shared by the top and by any block that drives Mode.
package scan_mux_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_rr_pick.sv
// Combinational cyclic priority finder: first set bit of En at or after ptr, wrapping.
module scan_mux_rr_pick #(
   parameter int unsigned CHANNELS = 16,
   parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] En,
   input  logic [SEL_W-1:0]    ptr,
   output logic [SEL_W-1:0]    idx,
   output logic                any
);

   always_comb begin
      int unsigned      cand;
      logic [SEL_W-1:0] cand_idx;
      idx      = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      // Walk offsets from farthest to nearest so the closest hit to ptr wins.
      for (int unsigned i = CHANNELS; i > 0; i--) begin
         cand = 32'(ptr) + i - 1;
         if (cand >= CHANNELS) begin
            cand = cand - CHANNELS;
         end
         cand_idx = SEL_W'(cand);
         if (En[cand_idx]) begin
            idx = cand_idx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/scan_mux.sv
// Two-stage pipelined N-channel selector with direct and round-robin scan modes
// and a valid/ready output handshake.
module scan_mux
   import scan_mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned CHANNELS = 16,
   parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      Clock,
   input  logic                      Resetn,
   input  logic [CHANNELS*WIDTH-1:0] W,
   input  logic                      Mode,
   input  logic [SEL_W-1:0]          S,
   input  logic [CHANNELS-1:0]       En,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          f,
   output logic [SEL_W-1:0]          ch
);

   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_data_q;
   logic [SEL_W-1:0] s1_idx_q;

   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic [SEL_W-1:0] issue_idx;
   logic             issue_valid;
   logic [WIDTH-1:0] issue_data;
   logic             adv;

   scan_mux_rr_pick #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_rr_pick (
      .En  (En),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign adv = !out_valid || out_ready;

   always_comb begin
      issue_idx   = '0;
      issue_valid = 1'b0;
      ptr_d       = ptr_q;
      unique case (Mode)
         MODE_DIRECT: begin
            issue_valid = 1'b1;
            // Out-of-range selects fall back to channel 0.
            issue_idx   = (32'(S) >= CHANNELS) ? '0 : S;
         end
         MODE_SCAN: begin
            issue_valid = pick_any;
            issue_idx   = pick_idx;
            if (pick_any) begin
               ptr_d = (pick_idx == SEL_W'(CHANNELS - 1)) ? '0 : pick_idx + SEL_W'(1);
            end
         end
      endcase
   end

   assign issue_data = W[32'(issue_idx) * WIDTH +: WIDTH];

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         ptr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_idx_q   <= '0;
         out_valid  <= 1'b0;
         f          <= '0;
         ch         <= '0;
      end else if (adv) begin
         ptr_q      <= ptr_d;
         s1_valid_q <= issue_valid;
         if (issue_valid) begin
            s1_data_q <= issue_data;
            s1_idx_q  <= issue_idx;
         end
         out_valid <= s1_valid_q;
         // Bubbles leave f/ch at the last delivered sample.
         if (s1_valid_q) begin
            f  <= s1_data_q;
            ch <= s1_idx_q;
         end
      end
   end

endmodule

// File: tb/tb_scan_mux.sv
// Directed self-checking bench for scan_mux (WIDTH=1, CHANNELS=16).
module tb_scan_mux;

   localparam int unsigned WIDTH    = 1;
   localparam int unsigned CHANNELS = 16;
   localparam int unsigned SEL_W    = 4;

   logic                      Clock = 1'b0;
   logic                      Resetn;
   logic [CHANNELS*WIDTH-1:0] W;
   logic                      Mode;
   logic [SEL_W-1:0]          S;
   logic [CHANNELS-1:0]       En;
   logic                      out_ready;
   logic                      out_valid;
   logic [WIDTH-1:0]          f;
   logic [SEL_W-1:0]          ch;

   int errors = 0;
   int checks = 0;
   logic [15:0] wv = 16'hA5C3;

   scan_mux #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .W         (W),
      .Mode      (Mode),
      .S         (S),
      .En        (En),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .f         (f),
      .ch        (ch)
   );

   always #5 Clock = ~Clock;

   task automatic step;
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset;
      Resetn = 1'b0;
      step();
      Resetn = 1'b1;
   endtask

   task automatic test_reset;
      Resetn = 1'b0; W = wv; Mode = 1'b0; S = 4'd5; En = '0; out_ready = 1'b1;
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || f !== 1'b0 || ch !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b f=%b ch=%0d, required 0/0/0", out_valid, f, ch);
      end
      Resetn = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL release_cycle1: got valid=%b, required 0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || f !== 1'b0 || ch !== 4'd5) begin
         errors++;
         $display("FAIL release_cycle2: got valid=%b f=%b ch=%0d, required 1/0/5", out_valid, f, ch);
      end
   endtask

   task automatic test_direct_sweep;
      logic [3:0] e;
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) S = 4'(i);
         step();
         if (i >= 1) begin
            e = 4'(i - 1);
            checks++;
            if (out_valid !== 1'b1 || ch !== e || f !== wv[e]) begin
               errors++;
               $display("FAIL direct_sweep: got valid=%b ch=%0d f=%b, required 1 ch=%0d f=%b",
                        out_valid, ch, f, e, wv[e]);
            end
         end
      end
   endtask

   task automatic test_sample_hold;
      do_reset();
      Mode = 1'b0; S = 4'd6;
      step();
      W = ~wv;
      step();
      checks++;
      if (out_valid !== 1'b1 || ch !== 4'd6 || f !== 1'b1) begin
         errors++;
         $display("FAIL sample_at_issue: got valid=%b ch=%0d f=%b, required 1 ch=6 f=1",
                  out_valid, ch, f);
      end
      W = wv;
   endtask

   task automatic test_scan_wrap;
      logic [3:0] seq [3] = '{4'd0, 4'd2, 4'd15};
      logic [3:0] e;
      do_reset();
      Mode = 1'b1; En = 16'h8005; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         if (k >= 1) begin
            e = seq[(k - 1) % 3];
            checks++;
            if (out_valid !== 1'b1 || ch !== e || f !== wv[e]) begin
               errors++;
               $display("FAIL scan_wrap: got valid=%b ch=%0d f=%b, required 1 ch=%0d f=%b",
                        out_valid, ch, f, e, wv[e]);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      do_reset();
      Mode = 1'b1; En = 16'h00FF; out_ready = 1'b1;
      step();
      step();
      step();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || ch !== 4'd1 || f !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b ch=%0d f=%b, required 1 ch=1 f=1",
                     out_valid, ch, f);
         end
      end
      out_ready = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || ch !== 4'(k) || f !== wv[k]) begin
            errors++;
            $display("FAIL stall_resume: got ch=%0d f=%b, required ch=%0d f=%b",
                     ch, f, k, wv[k]);
         end
      end
   endtask

   // Continues from test_backpressure: out=4, stage 1 holds 5, ptr=6.
   task automatic test_empty_mask;
      logic exp_v [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [3:0] exp_c [6] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd4};
      En = '0;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) En = 16'h0010;
         step();
         checks++;
         if (out_valid !== exp_v[k] || ch !== exp_c[k] || f !== 1'b0) begin
            errors++;
            $display("FAIL empty_mask[%0d]: got valid=%b ch=%0d f=%b, required %b ch=%0d f=0",
                     k, out_valid, ch, f, exp_v[k], exp_c[k]);
         end
      end
   endtask

   task automatic test_mode_switch;
      logic [3:0] exp_c [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd9, 4'd4, 4'd5};
      do_reset();
      Mode = 1'b1; En = 16'hFFFF; S = 4'd9;
      for (int k = 0; k <= 8; k++) begin
         if (k == 4) Mode = 1'b0;
         if (k == 6) Mode = 1'b1;
         step();
         if (k >= 1) begin
            checks++;
            if (out_valid !== 1'b1 || ch !== exp_c[k-1] || f !== wv[exp_c[k-1]]) begin
               errors++;
               $display("FAIL mode_switch: got ch=%0d f=%b, required ch=%0d f=%b",
                        ch, f, exp_c[k-1], wv[exp_c[k-1]]);
            end
         end
      end
   endtask

   // Continues from test_mode_switch with both stages valid.
   task automatic test_mid_reset;
      step();
      checks++;
      if (out_valid !== 1'b1 || ch !== 4'd6 || f !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got valid=%b ch=%0d f=%b, required 1 ch=6 f=1", out_valid, ch, f);
      end
      Resetn = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || ch !== 4'd0 || f !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got valid=%b ch=%0d f=%b, required 0/0/0", out_valid, ch, f);
      end
      Resetn = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_flush: got valid=%b, required 0", out_valid);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || ch !== 4'(k) || f !== wv[k]) begin
            errors++;
            $display("FAIL restart_scan: got valid=%b ch=%0d f=%b, required 1 ch=%0d f=%b",
                     out_valid, ch, f, k, wv[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_direct_sweep();
      test_sample_hold();
      test_scan_wrap();
      test_backpressure();
      test_empty_mask();
      test_mode_switch();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
